weight_buffer_ctrl: RTL and testbench

WEIGHT_BUFFER_CTRL -- requirements
Module: weight_buffer_ctrl

---
 rtl/conv_acc_pkg.sv | 16 +
 rtl/wb_row_ram.sv | 24 ++
 rtl/weight_buffer_ctrl.sv | 132 +++++++++++++
 tb/tb_weight_buffer_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_acc_pkg.sv
// Shared types and default sizing for the conv accelerator.
// Holds the weight buffer FSM state type and size defaults.
package conv_acc_pkg;

  localparam int WB_DATA_WIDTH = 16;
  localparam int WB_NUM_CH     = 4;
  localparam int WB_DEPTH      = 16;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_LOAD,
    WB_FULL,
    WB_FLUSH
  } wb_state_t;

endpackage

// File: rtl/wb_row_ram.sv
// Row storage for the weight buffer: DEPTH x W, sync write, comb read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module wb_row_ram #(
  parameter int W     = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/weight_buffer_ctrl.sv
// Weight row buffer: load rows, then stream them to the PE array on flush.
// Ports: wr_* load side, flush/retain/clear control, out_* stream, count.
module weight_buffer_ctrl
  import conv_acc_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int NUM_CH     = WB_NUM_CH,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  input  logic                         flush,
  input  logic                         retain,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         flush_done,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int RW = NUM_CH * DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic            ret_q, ret_d;
  logic            done_q, done_d;
  logic            we;
  logic            loading;
  logic            hs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      ret_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ret_q   <= ret_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    ret_d     = ret_q;
    done_d    = 1'b0;
    loading   = (state_q == WB_IDLE)
             || (state_q == WB_LOAD);
    wr_ready  = rstn && loading
             && !flush && !clear;
    we        = wr_valid && wr_ready;
    out_valid = (state_q == WB_FLUSH);
    out_last  = out_valid
             && ({1'b0, rd_q} == cnt_q - CW'(1));
    hs        = out_valid && out_ready;

    unique case (state_q)
      WB_IDLE, WB_LOAD, WB_FULL: begin
        if (clear) begin
          cnt_d   = '0;
          state_d = WB_IDLE;
        end else if (flush) begin
          // Empty flush completes at once with no stream.
          if (cnt_q == '0) begin
            done_d = 1'b1;
          end else begin
            ret_d   = retain;
            rd_d    = '0;
            state_d = WB_FLUSH;
          end
        end else if (we) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_d == CW'(DEPTH))
                  ? WB_FULL : WB_LOAD;
        end
      end
      WB_FLUSH: begin
        if (clear) begin
          cnt_d   = '0;
          rd_d    = '0;
          state_d = WB_IDLE;
        end else if (hs) begin
          if (out_last) begin
            done_d = 1'b1;
            rd_d   = '0;
            if (ret_q) begin
              state_d = (cnt_q == CW'(DEPTH))
                      ? WB_FULL : WB_LOAD;
            end else begin
              cnt_d   = '0;
              state_d = WB_IDLE;
            end
          end else begin
            rd_d = rd_q + AW'(1);
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  wb_row_ram #(
    .W     (RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (cnt_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_q),
    .rdata (out_data)
  );

  assign flush_done = done_q;
  assign count      = cnt_q;

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Self-checking bench for weight_buffer_ctrl.
// Row-list reference model plus directed and random scenarios.
module tb_weight_buffer_ctrl;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int DP = 16;
  localparam int RW = DW * NC;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_valid;
  logic          wr_ready;
  logic [RW-1:0] wr_data;
  logic          flush;
  logic          retain;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic          out_last;
  logic          flush_done;
  logic [4:0]    count;

  int checks = 0;
  int errors = 0;

  weight_buffer_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NC),
    .DEPTH      (DP)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .flush      (flush),
    .retain     (retain),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .flush_done (flush_done),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Reference model: a list of stored rows and a stream cursor.
  logic [RW-1:0] mrows [DP];
  int  mcount;
  bit  mflushing;
  int  midx;
  bit  mret;
  bit  mdone;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcount    <= 0;
      mflushing <= 0;
      midx      <= 0;
      mret      <= 0;
      mdone     <= 0;
    end else begin
      mdone <= 0;
      if (mflushing) begin
        if (clear) begin
          mflushing <= 0;
          mcount    <= 0;
        end else if (out_ready) begin
          if (midx == mcount - 1) begin
            mflushing <= 0;
            mdone     <= 1;
            if (!mret) mcount <= 0;
          end else begin
            midx <= midx + 1;
          end
        end
      end else if (clear) begin
        mcount <= 0;
      end else if (flush) begin
        if (mcount == 0) begin
          mdone <= 1;
        end else begin
          mflushing <= 1;
          midx      <= 0;
          mret      <= retain;
        end
      end else if (wr_valid && mcount < DP) begin
        mrows[mcount] <= wr_data;
        mcount        <= mcount + 1;
      end
    end
  end

  // Stream log and pulse counters used by directed checks.
  logic [RW-1:0] rxq [$];
  int done_cnt = 0;
  int vld_cnt  = 0;

  always @(negedge clk) begin
    logic exp_rdy;
    logic exp_last;
    exp_rdy  = rstn && !mflushing && (mcount < DP)
            && !flush && !clear;
    exp_last = mflushing && (midx == mcount - 1);
    chk("wr_ready", RW'(wr_ready), RW'(exp_rdy));
    chk("out_valid", RW'(out_valid), RW'(mflushing));
    chk("out_last", RW'(out_last), RW'(exp_last));
    chk("flush_done", RW'(flush_done), RW'(mdone));
    chk("count", RW'(count), RW'(mcount));
    if (mflushing)
      chk("out_data", out_data, mrows[midx]);
    if (flush_done) done_cnt++;
    if (out_valid) vld_cnt++;
    if (out_valid && out_ready && rstn)
      rxq.push_back(out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_valid  = 0;
    flush     = 0;
    clear     = 0;
    retain    = 0;
    out_ready = 1;
  endtask

  task automatic wr_row(input logic [RW-1:0] d);
    wr_valid = 1;
    wr_data  = d;
    step();
    wr_valid = 0;
  endtask

  task automatic pulse_flush(input bit r);
    flush  = 1;
    retain = r;
    step();
    flush  = 0;
    retain = 0;
  endtask

  task automatic pulse_clear();
    clear = 1;
    step();
    clear = 0;
  endtask

  function automatic logic [RW-1:0] lane_row(int v);
    logic [DW-1:0] l;
    l = DW'(v);
    return {l, l, l, l};
  endfunction

  task automatic ref_flush16();
    for (int i = 0; i < 16; i++)
      wr_row(lane_row(i + 1));
    chk("fill_cnt", RW'(count), RW'(16));
    rxq.delete();
    done_cnt = 0;
    vld_cnt  = 0;
    pulse_flush(0);
    chk("lat_vld", RW'(out_valid), RW'(1));
    for (int i = 0; i < 22; i++) step();
    chk("f16_n", RW'(rxq.size()), RW'(16));
    chk("f16_vn", RW'(vld_cnt), RW'(16));
    if (rxq.size() == 16) begin
      chk("f16_r0", rxq[0], 64'h0001000100010001);
      chk("f16_r15", rxq[15], 64'h0010001000100010);
    end
    chk("f16_done", RW'(done_cnt), RW'(1));
    chk("f16_cnt", RW'(count), RW'(0));
  endtask

  logic [RW-1:0] rx1 [$];
  logic [RW-1:0] rows8 [8];

  initial begin
    idle_in();
    wr_data = '0;
    rstn    = 0;
    #2;
    chk("rst_vld", RW'(out_valid), RW'(0));
    chk("rst_rdy", RW'(wr_ready), RW'(0));
    chk("rst_cnt", RW'(count), RW'(0));
    chk("rst_done", RW'(flush_done), RW'(0));
    step();
    step();
    rstn = 1;
    step();

    // Fill, flush and drain with retain=0.
    ref_flush16();

    // Overfill: 17th row refused, originals kept.
    for (int i = 0; i < 16; i++)
      wr_row(lane_row(i + 1));
    wr_valid = 1;
    wr_data  = lane_row(99);
    #1;
    chk("ovf_rdy", RW'(wr_ready), RW'(0));
    step();
    wr_valid = 0;
    chk("ovf_cnt", RW'(count), RW'(16));
    rxq.delete();
    pulse_flush(1);
    for (int i = 0; i < 20; i++) step();
    chk("ovf_n", RW'(rxq.size()), RW'(16));
    if (rxq.size() == 16)
      chk("ovf_r15", rxq[15], lane_row(16));
    chk("ovf_keep", RW'(count), RW'(16));
    pulse_clear();

    // Two retain flushes stream the same 5 rows.
    for (int i = 0; i < 5; i++)
      wr_row({$urandom, $urandom});
    rxq.delete();
    pulse_flush(1);
    for (int i = 0; i < 8; i++) step();
    rx1 = rxq;
    chk("ret1_cnt", RW'(count), RW'(5));
    rxq.delete();
    pulse_flush(1);
    for (int i = 0; i < 8; i++) step();
    chk("ret2_cnt", RW'(count), RW'(5));
    chk("ret_n", RW'(rxq.size()), RW'(5));
    if (rxq.size() == 5 && rx1.size() == 5)
      for (int i = 0; i < 5; i++)
        chk("ret_same", rxq[i], rx1[i]);
    wr_valid = 1;
    wr_data  = '0;
    #1;
    chk("ret_load", RW'(wr_ready), RW'(1));
    wr_valid = 0;
    pulse_clear();

    // Back-pressure on the 4th row of 8.
    for (int i = 0; i < 8; i++) begin
      rows8[i] = {$urandom, $urandom};
      wr_row(rows8[i]);
    end
    rxq.delete();
    pulse_flush(0);
    for (int i = 0; i < 20 && rxq.size() < 3; i++)
      step();
    chk("bp_reach", RW'(rxq.size()), RW'(3));
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", out_data, rows8[3]);
      chk("bp_vld", RW'(out_valid), RW'(1));
    end
    out_ready = 1;
    for (int i = 0; i < 10; i++) step();
    chk("bp_n", RW'(rxq.size()), RW'(8));
    if (rxq.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("bp_row", rxq[i], rows8[i]);

    // Empty flush, then flush+clear together.
    done_cnt = 0;
    vld_cnt  = 0;
    pulse_flush(0);
    for (int i = 0; i < 4; i++) step();
    chk("emp_done", RW'(done_cnt), RW'(1));
    chk("emp_vld", RW'(vld_cnt), RW'(0));
    for (int i = 0; i < 3; i++)
      wr_row(lane_row(i + 7));
    done_cnt = 0;
    vld_cnt  = 0;
    flush = 1;
    clear = 1;
    step();
    idle_in();
    for (int i = 0; i < 4; i++) step();
    chk("fc_cnt", RW'(count), RW'(0));
    chk("fc_done", RW'(done_cnt), RW'(0));
    chk("fc_vld", RW'(vld_cnt), RW'(0));

    // Reset in the middle of a flush.
    for (int i = 0; i < 8; i++)
      wr_row(lane_row(i + 40));
    rxq.delete();
    done_cnt = 0;
    pulse_flush(0);
    for (int i = 0; i < 20 && rxq.size() < 2; i++)
      step();
    #2;
    rstn = 0;
    #1;
    chk("mr_vld", RW'(out_valid), RW'(0));
    chk("mr_last", RW'(out_last), RW'(0));
    chk("mr_cnt", RW'(count), RW'(0));
    chk("mr_rdy", RW'(wr_ready), RW'(0));
    step();
    step();
    rstn = 1;
    step();
    chk("mr_done", RW'(done_cnt), RW'(0));
    ref_flush16();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      wr_valid  = ($urandom_range(0, 2) != 0);
      wr_data   = {$urandom, $urandom};
      flush     = ($urandom_range(0, 19) == 0);
      retain    = $urandom_range(0, 1);
      clear     = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    idle_in();
    for (int i = 0; i < 20; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
